// File: rtl/tinker_mem_pkg.sv
// Shared types and helpers for the Tinker memory unit.
package tinker_mem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} mem_state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} mem_size_t;
  typedef enum logic {FETCH, DATA} mem_owner_t;

  // Number of bytes touched by an access of the given size.
  function automatic logic [3:0] size_bytes(mem_size_t s);
    return 4'd1 << s;
  endfunction

endpackage

// File: rtl/tinker_mem_bank.sv
// Byte-addressed little-endian storage with a single masked 1..8 byte port.
// Callers must only request in-range accesses; indices wrap inside the bank.
module tinker_mem_bank
  import tinker_mem_pkg::*;
#(
  parameter int MEM_BYTES = 524288
) (
  input  logic                         clk,
  input  logic [$clog2(MEM_BYTES)-1:0] addr,
  input  logic [1:0]                   size,
  input  logic                         we,
  input  logic [63:0]                  wdata,
  output logic [63:0]                  rdata
);
  localparam int AW = $clog2(MEM_BYTES);

  logic [7:0] mem [MEM_BYTES];
  logic [3:0] nbytes;

  assign nbytes = size_bytes(mem_size_t'(size));

  // Zero-extended read of the low nbytes starting at addr.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < 8; i++)
      if (i < int'(nbytes)) rdata[8*i +: 8] = mem[addr + AW'(i)];
  end

  // Masked write: bytes above the access size are left alone.
  always_ff @(posedge clk) begin
    if (we)
      for (int i = 0; i < 8; i++)
        if (i < int'(nbytes)) mem[addr + AW'(i)] <= wdata[8*i +: 8];
  end

endmodule

// File: rtl/tinker_mem_unit.sv
// Multi-cycle memory unit: arbitrates fetch and data ports onto one bank,
// models access latency with a countdown FSM and flags bad addresses.
module tinker_mem_unit
  import tinker_mem_pkg::*;
#(
  parameter int MEM_BYTES   = 524288,
  parameter int ADDR_W      = 64,
  parameter int LATENCY     = 2,
  parameter int ALIGN_CHECK = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_instr,
  output logic              if_fault,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [63:0]       d_wdata,
  output logic              d_done,
  output logic [63:0]       d_rdata,
  output logic              d_fault,
  output logic              busy
);
  localparam int AW = $clog2(MEM_BYTES);

  mem_state_t        state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              enter_done;

  // Command latched at acceptance; inputs are ignored while WAIT.
  mem_owner_t        owner;
  logic              cmd_we;
  mem_size_t         cmd_size;
  logic [ADDR_W-1:0] cmd_addr;
  logic [63:0]       cmd_wdata;

  // Command in effect this cycle: live inputs in IDLE (needed for LATENCY=1),
  // the latched copy otherwise.
  logic              accept;
  mem_owner_t        cur_owner;
  logic              cur_we;
  mem_size_t         cur_size;
  logic [ADDR_W-1:0] cur_addr;
  logic [63:0]       cur_wdata;

  logic [3:0]        nbytes;
  logic [ADDR_W:0]   end_addr;
  logic              fault;
  logic              bank_we;
  logic [63:0]       bank_rdata;

  // Arbitration: data has fixed priority over fetch.
  always_comb begin
    accept    = 1'b0;
    cur_owner = owner;
    cur_we    = cmd_we;
    cur_size  = cmd_size;
    cur_addr  = cmd_addr;
    cur_wdata = cmd_wdata;
    if (state == IDLE) begin
      if (d_req) begin
        accept    = 1'b1;
        cur_owner = DATA;
        cur_we    = d_we;
        cur_size  = mem_size_t'(d_size);
        cur_addr  = d_addr;
        cur_wdata = d_wdata;
      end else if (if_req) begin
        accept    = 1'b1;
        cur_owner = FETCH;
        cur_we    = 1'b0;
        cur_size  = SZ_W;
        cur_addr  = if_addr;
        cur_wdata = '0;
      end
    end
  end

  // Range check in ADDR_W+1 bits so addresses near the top wrap into a fault.
  always_comb begin
    nbytes   = size_bytes(cur_size);
    end_addr = {1'b0, cur_addr} + {{(ADDR_W-3){1'b0}}, nbytes};
    fault    = (end_addr > (ADDR_W+1)'(MEM_BYTES)) ||
               ((ALIGN_CHECK != 0) && ((cur_addr[3:0] & (nbytes - 4'd1)) != 4'd0));
  end

  // Next state and latency countdown.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    enter_done = 1'b0;
    case (state)
      IDLE: if (accept) begin
        cnt_nxt = 4'(LATENCY - 1);
        if (LATENCY == 1) begin
          state_nxt  = DONE;
          enter_done = 1'b1;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          state_nxt  = DONE;
          enter_done = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stores commit on the edge entering DONE; reset on that edge wins.
  assign bank_we = enter_done && (cur_owner == DATA) && cur_we && !fault && !reset;
  assign busy    = (state != IDLE);

  tinker_mem_bank #(.MEM_BYTES(MEM_BYTES)) u_bank (
    .clk   (clk),
    .addr  (cur_addr[AW-1:0]),
    .size  (cur_size),
    .we    (bank_we),
    .wdata (cur_wdata),
    .rdata (bank_rdata)
  );

  // State, command latch and registered responses (valid only in DONE).
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      owner     <= FETCH;
      cmd_we    <= 1'b0;
      cmd_size  <= SZ_B;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      if_done   <= 1'b0;
      if_instr  <= '0;
      if_fault  <= 1'b0;
      d_done    <= 1'b0;
      d_rdata   <= '0;
      d_fault   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        owner     <= cur_owner;
        cmd_we    <= cur_we;
        cmd_size  <= cur_size;
        cmd_addr  <= cur_addr;
        cmd_wdata <= cur_wdata;
      end
      if_done  <= enter_done && (cur_owner == FETCH);
      if_fault <= enter_done && (cur_owner == FETCH) && fault;
      if_instr <= (enter_done && (cur_owner == FETCH) && !fault) ? bank_rdata[31:0] : '0;
      d_done   <= enter_done && (cur_owner == DATA);
      d_fault  <= enter_done && (cur_owner == DATA) && fault;
      d_rdata  <= (enter_done && (cur_owner == DATA) && !cur_we && !fault) ? bank_rdata : '0;
    end
  end

endmodule

// File: tb/tb_tinker_mem_unit.sv
// Scoreboard bench for tinker_mem_unit: three instances cover LATENCY 2, 4, 1.
module tb_tinker_mem_unit;
  localparam int MEM0 = 524288;
  localparam int MEMS = 4096;

  logic        clk = 1'b0;
  logic        rst      [3];
  logic        if_req   [3];
  logic [63:0] if_addr  [3];
  logic        if_done  [3];
  logic [31:0] if_instr [3];
  logic        if_fault [3];
  logic        d_req    [3];
  logic        d_we     [3];
  logic [1:0]  d_size   [3];
  logic [63:0] d_addr   [3];
  logic [63:0] d_wdata  [3];
  logic        d_done   [3];
  logic [63:0] d_rdata  [3];
  logic        d_fault  [3];
  logic        busy     [3];

  int lat [3] = '{2, 4, 1};
  int checks = 0;
  int passes = 0;

  typedef struct {
    int          k;
    bit          ft;
    logic [63:0] rd;
    bit          flt;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  tinker_mem_unit #(.MEM_BYTES(MEM0), .ADDR_W(64), .LATENCY(2), .ALIGN_CHECK(1)) u0 (
    .clk(clk), .reset(rst[0]), .if_req(if_req[0]), .if_addr(if_addr[0]), .if_done(if_done[0]),
    .if_instr(if_instr[0]), .if_fault(if_fault[0]), .d_req(d_req[0]), .d_we(d_we[0]),
    .d_size(d_size[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]), .d_done(d_done[0]),
    .d_rdata(d_rdata[0]), .d_fault(d_fault[0]), .busy(busy[0]));

  tinker_mem_unit #(.MEM_BYTES(MEMS), .ADDR_W(64), .LATENCY(4), .ALIGN_CHECK(1)) u1 (
    .clk(clk), .reset(rst[1]), .if_req(if_req[1]), .if_addr(if_addr[1]), .if_done(if_done[1]),
    .if_instr(if_instr[1]), .if_fault(if_fault[1]), .d_req(d_req[1]), .d_we(d_we[1]),
    .d_size(d_size[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]), .d_done(d_done[1]),
    .d_rdata(d_rdata[1]), .d_fault(d_fault[1]), .busy(busy[1]));

  tinker_mem_unit #(.MEM_BYTES(MEMS), .ADDR_W(64), .LATENCY(1), .ALIGN_CHECK(1)) u2 (
    .clk(clk), .reset(rst[2]), .if_req(if_req[2]), .if_addr(if_addr[2]), .if_done(if_done[2]),
    .if_instr(if_instr[2]), .if_fault(if_fault[2]), .d_req(d_req[2]), .d_we(d_we[2]),
    .d_size(d_size[2]), .d_addr(d_addr[2]), .d_wdata(d_wdata[2]), .d_done(d_done[2]),
    .d_rdata(d_rdata[2]), .d_fault(d_fault[2]), .busy(busy[2]));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic chk_zero(input int k, input string tag);
    chk({tag, "_if_done"},  64'(if_done[k]),  64'd0);
    chk({tag, "_if_instr"}, 64'(if_instr[k]), 64'd0);
    chk({tag, "_if_fault"}, 64'(if_fault[k]), 64'd0);
    chk({tag, "_d_done"},   64'(d_done[k]),   64'd0);
    chk({tag, "_d_rdata"},  d_rdata[k],       64'd0);
    chk({tag, "_d_fault"},  64'(d_fault[k]),  64'd0);
    chk({tag, "_busy"},     64'(busy[k]),     64'd0);
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (d_done[k] || if_done[k]) begin
        chk("one_port", 64'(d_done[k] & if_done[k]), 64'd0);
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_done: inst %0d d_done %0b if_done %0b, none expected", k, d_done[k], if_done[k]);
        end else begin
          e = sb.pop_front();
          chk("inst",  64'(k), 64'(e.k));
          chk("port",  64'(if_done[k]), 64'(e.ft));
          chk("rdata", if_done[k] ? {32'd0, if_instr[k]} : d_rdata[k], e.rd);
          chk("fault", 64'(if_done[k] ? if_fault[k] : d_fault[k]), 64'(e.flt));
        end
      end
    end
  end

  // One request through to completion; checks latency and busy along the way.
  task automatic access(input int k, input bit ft, input bit we, input logic [1:0] sz,
                        input logic [63:0] addr, input logic [63:0] wd,
                        input logic [63:0] exp_rd, input bit exp_f);
    int n = 0;
    bit seen = 0;
    sb.push_back('{k, ft, exp_rd, exp_f});
    @(negedge clk);
    if (ft) begin
      if_req[k] = 1'b1; if_addr[k] = addr;
    end else begin
      d_req[k] = 1'b1; d_we[k] = we; d_size[k] = sz; d_addr[k] = addr; d_wdata[k] = wd;
    end
    while (!seen && n < 40) begin
      @(posedge clk); #1; n++;
      if (ft ? if_done[k] : d_done[k]) seen = 1;
      else chk("busy_wait", 64'(busy[k]), 64'd1);
    end
    if_req[k] = 1'b0;
    d_req[k]  = 1'b0;
    chk("latency", 64'(n), 64'(lat[k]));
    chk("busy_done", 64'(busy[k]), 64'd1);
    @(posedge clk); #1;
    chk("busy_idle", 64'(busy[k]), 64'd0);
  endtask

  initial begin
    int n, dn, fn;
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; if_req[k] = 1'b0; if_addr[k] = '0; d_req[k] = 1'b0; d_we[k] = 1'b0;
      d_size[k] = '0; d_addr[k] = '0; d_wdata[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk_zero(k, "reset");
    @(negedge clk);
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;

    // Preload through the data port.
    access(0, 0, 1, 2'd2, 64'h2000, 64'h1234_5678, 64'd0, 0);
    access(0, 0, 1, 2'd3, 64'h100, 64'h0123_4567_89AB_CDEF, 64'd0, 0);
    access(0, 0, 1, 2'd2, 64'(MEM0 - 4), 64'hCAFE_F00D, 64'd0, 0);

    // Reset held 2 cycles, then a fetch.
    @(negedge clk); rst[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1; chk_zero(0, "reset2");
    @(negedge clk); rst[0] = 1'b0;
    access(0, 1, 0, 2'd0, 64'h2000, 64'd0, 64'h1234_5678, 0);

    // Halfword store leaves upper bytes of the dword alone.
    access(0, 0, 1, 2'd1, 64'h100, 64'hFFFF_FFFF_FFFF_BEEF, 64'd0, 0);
    access(0, 0, 0, 2'd3, 64'h100, 64'd0, 64'h0123_4567_89AB_BEEF, 0);

    // Arbitration: data first, fetch LATENCY+1 cycles later.
    sb.push_back('{0, 0, 64'h0123_4567_89AB_BEEF, 0});
    sb.push_back('{0, 1, 64'h1234_5678, 0});
    @(negedge clk);
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_size[0] = 2'd3; d_addr[0] = 64'h100;
    if_req[0] = 1'b1; if_addr[0] = 64'h2000;
    n = 0; dn = 0; fn = 0;
    while (fn == 0 && n < 30) begin
      @(posedge clk); #1; n++;
      if (d_done[0])  begin dn = n; d_req[0]  = 1'b0; end
      if (if_done[0]) begin fn = n; if_req[0] = 1'b0; end
    end
    if_req[0] = 1'b0; d_req[0] = 1'b0;
    chk("arb_d_latency", 64'(dn), 64'd2);
    chk("arb_gap", 64'(fn - dn), 64'd3);
    @(posedge clk);

    // Faults and top-of-array boundary.
    access(0, 0, 0, 2'd3, 64'h103, 64'd0, 64'd0, 1);
    access(0, 0, 1, 2'd2, 64'(MEM0 - 2), 64'h1122_3344, 64'd0, 1);
    access(0, 0, 0, 2'd2, 64'(MEM0 - 4), 64'd0, 64'hCAFE_F00D, 0);
    access(0, 0, 0, 2'd1, 64'(MEM0 - 2), 64'd0, 64'hCAFE, 0);
    access(0, 1, 0, 2'd0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 64'd0, 1);

    // LATENCY=4: reset on the commit edge aborts the store.
    access(1, 0, 1, 2'd0, 64'h200, 64'h5A, 64'd0, 0);
    @(negedge clk);
    d_req[1] = 1'b1; d_we[1] = 1'b1; d_size[1] = 2'd0; d_addr[1] = 64'h200; d_wdata[1] = 64'hAA;
    repeat (3) @(negedge clk);
    chk("abort_busy", 64'(busy[1]), 64'd1);
    rst[1] = 1'b1; d_req[1] = 1'b0;
    @(posedge clk); #1;
    chk_zero(1, "abort");
    @(negedge clk); rst[1] = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("abort_no_done", 64'(d_done[1]), 64'd0);
    end
    access(1, 0, 0, 2'd0, 64'h200, 64'd0, 64'h5A, 0);

    // LATENCY=1: held request re-issues, done every other cycle.
    access(2, 0, 1, 2'd0, 64'h10, 64'h77, 64'd0, 0);
    repeat (3) sb.push_back('{2, 0, 64'h77, 0});
    @(negedge clk);
    d_req[2] = 1'b1; d_we[2] = 1'b0; d_size[2] = 2'd0; d_addr[2] = 64'h10;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      chk("b2b_done", 64'(d_done[2]), 64'(c % 2));
      if (c == 5) d_req[2] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_idle", 64'(busy[2]), 64'd0);

    @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
